// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: mnemonic codes, opcodes, field widths,
// the NOP word and the encoder state type.
// Optional feature macro used by the encoder: DELAY_SLOT_NOP_EN.
package mips_isa_pkg;

   localparam int MNEM_W  = 4;
   localparam int OPC_W   = 6;
   localparam int REG_W   = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;
   localparam int TGT_W   = 26;
   localparam int WORD_W  = 32;

   typedef enum logic [MNEM_W-1:0] {
      MN_RTYPE = 4'd0,
      MN_ADDI  = 4'd1,
      MN_ORI   = 4'd2,
      MN_ANDI  = 4'd3,
      MN_LUI   = 4'd4,
      MN_LW    = 4'd5,
      MN_SW    = 4'd6,
      MN_BEQ   = 4'd7,
      MN_BNE   = 4'd8,
      MN_J     = 4'd9,
      MN_JAL   = 4'd10
   } mnem_e;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPC_W-1:0] OP_J     = 6'h02;
   localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0c;
   localparam logic [OPC_W-1:0] OP_ORI   = 6'h0d;
   localparam logic [OPC_W-1:0] OP_LUI   = 6'h0f;
   localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPC_W-1:0] OP_SW    = 6'h2b;

   localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FULL = 2'd2
   } enc_state_e;

   // True for mnemonics that have a branch delay slot.
   function automatic logic is_ctrl_xfer(input logic [MNEM_W-1:0] m);
      return (m == MN_BEQ) || (m == MN_BNE) || (m == MN_J) || (m == MN_JAL);
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Purely combinational packer: mnemonic plus fields -> 32-bit MIPS word,
// with an illegal flag for the unused mnemonic codes 11..15.
module instr_field_pack
   import mips_isa_pkg::*;
(
   input  logic [MNEM_W-1:0]  mnemonic,
   input  logic [REG_W-1:0]   rs,
   input  logic [REG_W-1:0]   rt,
   input  logic [REG_W-1:0]   rd,
   input  logic [REG_W-1:0]   shamt,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [IMM_W-1:0]   imm,
   input  logic [TGT_W-1:0]   target,
   output logic [WORD_W-1:0]  word,
   output logic               illegal
);

   // Select the instruction format by mnemonic; LUI forces the rs field to 0.
   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (mnemonic)
         MN_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
         MN_ADDI:  word = {OP_ADDI, rs, rt, imm};
         MN_ORI:   word = {OP_ORI, rs, rt, imm};
         MN_ANDI:  word = {OP_ANDI, rs, rt, imm};
         MN_LUI:   word = {OP_LUI, 5'd0, rt, imm};
         MN_LW:    word = {OP_LW, rs, rt, imm};
         MN_SW:    word = {OP_SW, rs, rt, imm};
         MN_BEQ:   word = {OP_BEQ, rs, rt, imm};
         MN_BNE:   word = {OP_BNE, rs, rt, imm};
         MN_J:     word = {OP_J, target};
         MN_JAL:   word = {OP_JAL, target};
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts symbolic beats over valid/ready and writes
// packed MIPS words to consecutive instruction-memory addresses.
// Optional macro DELAY_SLOT_NOP_EN: auto-insert a NOP after each branch/jump.
//
// Handshakes: an input beat transfers on a cycle where InValid && InReady;
// a memory write transfers on a cycle where MemWrEn && MemAck, and MemWrEn,
// MemAddr and MemData stay stable until that cycle.
module instr_encoder
   import mips_isa_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 256,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic [MNEM_W-1:0]     Mnemonic,
   input  logic [REG_W-1:0]      Rs,
   input  logic [REG_W-1:0]      Rt,
   input  logic [REG_W-1:0]      Rd,
   input  logic [REG_W-1:0]      Shamt,
   input  logic [FUNCT_W-1:0]    Funct,
   input  logic [IMM_W-1:0]      Imm,
   input  logic [TGT_W-1:0]      Target,
   output logic                  MemWrEn,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [WORD_W-1:0]     MemData,
   input  logic                  MemAck,
   output logic [ADDR_WIDTH:0]   Count,
   output logic                  Full,
   output logic                  Error,
   output logic [1:0]            DbgState
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

   enc_state_e              state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;         // address for the next word
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0]       mem_data_q, mem_data_d;
   logic                    wr_q, wr_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   logic                    counted_q, counted_d;   // pending word counts toward Count
   logic                    error_q, error_d;
`ifdef DELAY_SLOT_NOP_EN
   logic                    branch_q, branch_d;     // pending word needs a delay-slot NOP
`endif

   logic [WORD_W-1:0]       packed_word;
   logic                    packed_illegal;
   logic                    ack_fire;
   logic                    hits_full;
   logic                    slot_block;
   logic                    in_ready;
   logic [ADDR_WIDTH:0]     count_inc;

   instr_field_pack u_pack (
      .mnemonic (Mnemonic),
      .rs       (Rs),
      .rt       (Rt),
      .rd       (Rd),
      .shamt    (Shamt),
      .funct    (Funct),
      .imm      (Imm),
      .target   (Target),
      .word     (packed_word),
      .illegal  (packed_illegal)
   );

   // Next-state logic: write completion, Start re-arm, then beat acceptance.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      wr_d       = wr_q;
      count_d    = count_q;
      counted_d  = counted_q;
      error_d    = error_q;
`ifdef DELAY_SLOT_NOP_EN
      branch_d   = branch_q;
      slot_block = wr_q & branch_q & counted_q;
`else
      slot_block = 1'b0;
`endif
      ack_fire  = wr_q & MemAck;
      count_inc = count_q + 1'b1;
      hits_full = counted_q & (count_inc == DEPTH_C);
      // Beats are refused during Start so re-arming never races an accept;
      // the last slot's ack drops InReady in the same cycle.
      in_ready  = (state_q == ST_RUN) & ~Start & (~wr_q | MemAck)
                & ~(ack_fire & hits_full) & ~slot_block;

      if (ack_fire) begin
         wr_d      = 1'b0;
         counted_d = 1'b0;
         if (counted_q) begin
            count_d = count_inc;
            addr_d  = addr_q + 1'b1;
            if (hits_full) begin
               state_d = ST_FULL;
            end
`ifdef DELAY_SLOT_NOP_EN
            else if (branch_q) begin
               wr_d       = 1'b1;
               counted_d  = 1'b1;
               mem_addr_d = addr_q + 1'b1;
               mem_data_d = NOP_WORD;
            end
`endif
         end
`ifdef DELAY_SLOT_NOP_EN
         branch_d = 1'b0;
`endif
      end

      // A pending word still completes after Start but is no longer counted.
      if (Start) begin
         state_d   = ST_RUN;
         count_d   = '0;
         addr_d    = BASE_C;
         error_d   = 1'b0;
         counted_d = 1'b0;
         if (ack_fire) begin
            wr_d = 1'b0;
         end
`ifdef DELAY_SLOT_NOP_EN
         branch_d = 1'b0;
`endif
      end

      if (InValid && in_ready) begin
         if (packed_illegal) begin
            error_d = 1'b1;
         end else begin
            wr_d       = 1'b1;
            counted_d  = 1'b1;
            mem_addr_d = addr_d;
            mem_data_d = packed_word;
`ifdef DELAY_SLOT_NOP_EN
            branch_d   = is_ctrl_xfer(Mnemonic);
`endif
         end
      end
   end

   // State and output registers; reset drops any pending write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= BASE_C;
         mem_addr_q <= BASE_C;
         mem_data_q <= '0;
         wr_q       <= 1'b0;
         count_q    <= '0;
         counted_q  <= 1'b0;
         error_q    <= 1'b0;
`ifdef DELAY_SLOT_NOP_EN
         branch_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         wr_q       <= wr_d;
         count_q    <= count_d;
         counted_q  <= counted_d;
         error_q    <= error_d;
`ifdef DELAY_SLOT_NOP_EN
         branch_q   <= branch_d;
`endif
      end
   end

   assign InReady  = in_ready;
   assign MemWrEn  = wr_q;
   assign MemAddr  = mem_addr_q;
   assign MemData  = mem_data_q;
   assign Count    = count_q;
   assign Full     = (state_q == ST_FULL);
   assign Error    = error_q;
   assign DbgState = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance and a DEPTH=4
// instance sharing the field inputs. Honors DELAY_SLOT_NOP_EN when defined.
module tb_instr_encoder;

   logic        clk;
   logic        reset;
   logic        Start, InValid, MemAck;
   logic        Start4, InValid4, MemAck4;
   logic [3:0]  Mnemonic;
   logic [4:0]  Rs, Rt, Rd, Shamt;
   logic [5:0]  Funct;
   logic [15:0] Imm;
   logic [25:0] Target;

   logic        InReady, MemWrEn, Full, Error;
   logic [7:0]  MemAddr;
   logic [31:0] MemData;
   logic [8:0]  Count;
   logic [1:0]  DbgState;

   logic        InReady4, MemWrEn4, Full4, Error4;
   logic [1:0]  MemAddr4;
   logic [31:0] MemData4;
   logic [2:0]  Count4;
   logic [1:0]  DbgState4;

   int n_assert = 0;
   int n_fail   = 0;

   instr_encoder dut (
      .clk(clk), .reset(reset), .Start(Start), .InValid(InValid), .InReady(InReady),
      .Mnemonic(Mnemonic), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
      .Imm(Imm), .Target(Target), .MemWrEn(MemWrEn), .MemAddr(MemAddr),
      .MemData(MemData), .MemAck(MemAck), .Count(Count), .Full(Full),
      .Error(Error), .DbgState(DbgState)
   );

   instr_encoder #(.ADDR_WIDTH(2), .DEPTH(4), .BASE_ADDR(0)) dut4 (
      .clk(clk), .reset(reset), .Start(Start4), .InValid(InValid4), .InReady(InReady4),
      .Mnemonic(Mnemonic), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
      .Imm(Imm), .Target(Target), .MemWrEn(MemWrEn4), .MemAddr(MemAddr4),
      .MemData(MemData4), .MemAck(MemAck4), .Count(Count4), .Full(Full4),
      .Error(Error4), .DbgState(DbgState4)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] tgt);
      Mnemonic = m; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Funct = fn; Imm = imm; Target = tgt;
   endtask

   initial begin
      reset = 1'b0; Start = 1'b0; InValid = 1'b0; MemAck = 1'b1;
      Start4 = 1'b0; InValid4 = 1'b0; MemAck4 = 1'b1;
      beat(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1;

      // Reset state
      chk("rst_inready", {31'd0, InReady}, 32'd0);
      chk("rst_wren",    {31'd0, MemWrEn}, 32'd0);
      chk("rst_full",    {31'd0, Full}, 32'd0);
      chk("rst_error",   {31'd0, Error}, 32'd0);
      chk("rst_addr",    {24'd0, MemAddr}, 32'd0);
      chk("rst_data",    MemData, 32'd0);
      chk("rst_count",   {23'd0, Count}, 32'd0);

      // 1: ADDI with MemAck tied high
      Start = 1'b1; tick(); Start = 1'b0;
      beat(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
      InValid = 1'b1; #1;
      chk("t1_inready", {31'd0, InReady}, 32'd1);
      tick(); InValid = 1'b0; #1;
      chk("t1_wren",  {31'd0, MemWrEn}, 32'd1);
      chk("t1_addr",  {24'd0, MemAddr}, 32'd0);
      chk("t1_data",  MemData, 32'h20220005);
      tick();
      chk("t1_count", {23'd0, Count}, 32'd1);
      chk("t1_wren_low", {31'd0, MemWrEn}, 32'd0);

      // 2: RTYPE then LUI back to back
      beat(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'd0);
      InValid = 1'b1; tick();
      beat(4'd4, 5'd7, 5'd4, 5'd0, 5'd0, 6'h0, 16'h1234, 26'd0); #1;
      chk("t2_rtype_data", MemData, 32'h00221820);
      chk("t2_rtype_addr", {24'd0, MemAddr}, 32'd1);
      chk("t2_passthru",   {31'd0, InReady}, 32'd1);
      tick(); InValid = 1'b0; #1;
      chk("t2_lui_data", MemData, 32'h3C041234);
      chk("t2_lui_addr", {24'd0, MemAddr}, 32'd2);
      chk("t2_count",    {23'd0, Count}, 32'd2);
      tick();
      chk("t2_count_end", {23'd0, Count}, 32'd3);

      // 3: ack withheld for 3 cycles with a second beat pending
      MemAck = 1'b0;
      beat(4'd2, 5'd5, 5'd6, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'd0);
      InValid = 1'b1; tick();
      beat(4'd3, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'd0); #1;
      for (int i = 0; i < 3; i++) begin
         chk("t3_stall_ready", {31'd0, InReady}, 32'd0);
         chk("t3_stall_wren",  {31'd0, MemWrEn}, 32'd1);
         chk("t3_stall_data",  MemData, 32'h34A6FFFF);
         chk("t3_stall_addr",  {24'd0, MemAddr}, 32'd3);
         tick();
      end
      MemAck = 1'b1; #1;
      chk("t3_ack_ready", {31'd0, InReady}, 32'd1);
      tick(); InValid = 1'b0; #1;
      chk("t3_andi_data", MemData, 32'h300100FF);
      chk("t3_andi_addr", {24'd0, MemAddr}, 32'd4);
      chk("t3_count",     {23'd0, Count}, 32'd4);
      tick();
      chk("t3_count_end", {23'd0, Count}, 32'd5);

      // 4: illegal mnemonic, then Start clears Error
      beat(4'd13, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'd1);
      InValid = 1'b1; tick(); InValid = 1'b0; #1;
      chk("t4_error", {31'd0, Error}, 32'd1);
      chk("t4_nowr",  {31'd0, MemWrEn}, 32'd0);
      tick();
      chk("t4_count", {23'd0, Count}, 32'd5);
      Start = 1'b1; tick(); Start = 1'b0;
      chk("t4_error_clr", {31'd0, Error}, 32'd0);
      chk("t4_count_clr", {23'd0, Count}, 32'd0);
      beat(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
      InValid = 1'b1; tick(); InValid = 1'b0;
      chk("t4_rebase_addr", {24'd0, MemAddr}, 32'd0);
      tick();
      chk("t4_rebase_count", {23'd0, Count}, 32'd1);

      // Start while a write is pending: word completes, uncounted
      MemAck = 1'b0;
      beat(4'd6, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0);
      InValid = 1'b1; tick(); InValid = 1'b0;
      chk("sp_sw_data", MemData, 32'hAC640010);
      chk("sp_sw_addr", {24'd0, MemAddr}, 32'd1);
      Start = 1'b1; tick(); Start = 1'b0;
      chk("sp_count0",  {23'd0, Count}, 32'd0);
      chk("sp_pending", {31'd0, MemWrEn}, 32'd1);
      chk("sp_addr",    {24'd0, MemAddr}, 32'd1);
      MemAck = 1'b1; tick();
      chk("sp_done",      {31'd0, MemWrEn}, 32'd0);
      chk("sp_uncounted", {23'd0, Count}, 32'd0);
      beat(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
      InValid = 1'b1; tick(); InValid = 1'b0;
      chk("sp_next_addr", {24'd0, MemAddr}, 32'd0);
      tick();

      // 5: DEPTH=4 instance, five beats offered
      Start4 = 1'b1; tick(); Start4 = 1'b0;
      InValid4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         beat(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0); #1;
         chk("t5_ready", {31'd0, InReady4}, 32'd1);
         tick();
         chk("t5_addr", {30'd0, MemAddr4}, 32'(i));
         chk("t5_data", MemData4, 32'h20220000 | 32'(i));
      end
      beat(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0); #1;
      chk("t5_last_ack_ready", {31'd0, InReady4}, 32'd0);
      tick();
      chk("t5_full",  {31'd0, Full4}, 32'd1);
      chk("t5_count", {29'd0, Count4}, 32'd4);
      chk("t5_wren",  {31'd0, MemWrEn4}, 32'd0);
      chk("t5_stall", {31'd0, InReady4}, 32'd0);
      tick();
      chk("t5_stall2", {31'd0, InReady4}, 32'd0);
      chk("t5_nowr",   {31'd0, MemWrEn4}, 32'd0);
      Start4 = 1'b1; tick(); Start4 = 1'b0; #1;
      chk("t5_rearm_full",  {31'd0, Full4}, 32'd0);
      chk("t5_rearm_ready", {31'd0, InReady4}, 32'd1);
      tick(); InValid4 = 1'b0;
      chk("t5_5th_addr", {30'd0, MemAddr4}, 32'd0);
      chk("t5_5th_data", MemData4, 32'h20220004);
      tick();
      chk("t5_rearm_count", {29'd0, Count4}, 32'd1);

      // 6: jump with or without delay-slot insertion
      Start = 1'b1; tick(); Start = 1'b0;
      beat(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010);
      InValid = 1'b1; #1;
      chk("t6_ready", {31'd0, InReady}, 32'd1);
      tick(); InValid = 1'b0; #1;
      chk("t6_j_data", MemData, 32'h08000010);
      chk("t6_j_addr", {24'd0, MemAddr}, 32'd0);
`ifdef DELAY_SLOT_NOP_EN
      chk("t6_block_ready", {31'd0, InReady}, 32'd0);
      tick();
      chk("t6_nop_wren",  {31'd0, MemWrEn}, 32'd1);
      chk("t6_nop_data",  MemData, 32'h00000000);
      chk("t6_nop_addr",  {24'd0, MemAddr}, 32'd1);
      chk("t6_nop_count", {23'd0, Count}, 32'd1);
      tick();
      chk("t6_count", {23'd0, Count}, 32'd2);
      chk("t6_idle_wr", {31'd0, MemWrEn}, 32'd0);
`else
      chk("t6_ready_after", {31'd0, InReady}, 32'd1);
      tick();
      chk("t6_count", {23'd0, Count}, 32'd1);
      chk("t6_idle_wr", {31'd0, MemWrEn}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the opcode control decoder. Accepts symbolic instruction beats (mnemonic plus fields) over a valid/ready handshake.
- Packs each beat into a 32-bit MIPS word and writes it to instruction memory at consecutive word addresses through a held-until-ack write port.
- Used by the program loader and test infrastructure to fill instruction ROM/RAM before the unicycle core runs.

Parameters:
- ADDR_WIDTH, 8: word-address width of the instruction memory port.
- DEPTH, 256: number of writable words; must be ≤ 2^ADDR_WIDTH.
- BASE_ADDR, 0: first word address written after Start.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; (re)arms the encoder at BASE_ADDR.
- InValid  in  1  instruction beat valid.
- InReady  out  1  encoder can accept a beat this cycle.
- Mnemonic  in  4  0 RTYPE, 1 ADDI, 2 ORI, 3 ANDI, 4 LUI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J, 10 JAL; 11–15 illegal.
- Rs, Rt, Rd, Shamt  in  5 each  register and shift fields.
- Funct  in  6  R-type function field.
- Imm  in  16  I-type immediate.
- Target  in  26  J-type target.
- MemWrEn  out  1  write request; held until MemAck.
- MemAddr  out  ADDR_WIDTH  word address.
- MemData  out  32  encoded instruction.
- MemAck  in  1  memory accepted the write this cycle.
- Count  out  ADDR_WIDTH+1  words written since Start.
- Full  out  1  DEPTH words written.
- Error  out  1  sticky; an illegal mnemonic was received.

Behaviour:
- Reset values:
  - state IDLE.
  - InReady, MemWrEn, Full, Error = 0.
  - MemAddr = BASE_ADDR; MemData = 0; Count = 0.
- FSM states and transitions:
  - IDLE: InReady = 0. On Start → RUN.
  - RUN: InReady = !MemWrEn | MemAck (pass-through when the output register drains this cycle).
  - FULL: InReady = 0, Full = 1. On Start → RUN.
  - Any state: Start → RUN, Count = 0, next address = BASE_ADDR, Error cleared, Full cleared.
- Accept rule:
  - A beat is accepted when InValid & InReady.
  - Legal beat: MemData/MemAddr are loaded and MemWrEn rises the next cycle (latency 1).
  - Illegal beat: it is consumed, Error is set, and nothing is written.
- Encoding:
  - RTYPE: {6'h00, Rs, Rt, Rd, Shamt, Funct}.
  - ADDI 08, ORI 0d, ANDI 0c, LW 23, SW 2b, BEQ 04, BNE 05: {op, Rs, Rt, Imm}.
  - LUI 0f: {6'h0f, 5'd0, Rt, Imm}; Rs is ignored.
  - J 02, JAL 03: {op, Target}.
- Write completion:
  - On MemAck, Count increments and the next address increments.
  - When Count reaches DEPTH, the state moves to FULL on that ack edge and InReady deasserts the same cycle.
  - The address never wraps; beats offered in FULL are stalled, not dropped.
- Start while a write is pending: the pending word completes at its latched address but is not counted. Counting restarts from 0 after the Start.
- MemAck while MemWrEn = 0 is ignored.
- Reset mid-write drops the pending word immediately (asynchronous reset).

Optional Feature:
- Macro: DELAY_SLOT_NOP_EN.
- Defined:
  - After each legal BEQ, BNE, J or JAL write is acked, the encoder auto-writes NOP (32'h00000000) at the next address.
  - InReady is held 0 until the NOP is acked. The NOP counts toward Count and Full.
  - If the branch/jump fills the last slot (Count = DEPTH), no NOP is written and the state goes to FULL.
- Undefined: no insertion; one input beat produces exactly one word.

Decomposition:
- Package mips_isa_pkg:
  - Mnemonic enum/constants.
  - Opcode localparams (shared with the control decoder).
  - NOP word constant.
  - Field width constants.
- Sub-module instr_field_pack: purely combinational; Mnemonic plus fields → {word[31:0], illegal}.
- instr_encoder holds the FSM, output register, address counter and Count.

Test Plan:
1. Start, then ADDI Rs=1 Rt=2 Imm=16'h0005 with MemAck tied 1 → MemWrEn one cycle later, MemAddr=0, MemData=32'h20220005, Count=1.
2. RTYPE Rs=1 Rt=2 Rd=3 Shamt=0 Funct=6'h20, then LUI Rs=7 Rt=4 Imm=16'h1234 → 32'h00221820, then 32'h3C041234 (Rs forced 0).
3. MemAck held 0 for 3 cycles with a second beat pending → MemWrEn/MemData stable, InReady=0; on ack the next beat is accepted the same cycle (pass-through).
4. Mnemonic=4'd13 → no write, Error=1, Count unchanged; Start → Error=0.
5. DEPTH=4: 5 beats offered → 4 writes at addresses 0–3, Full=1, 5th beat stalled with InReady=0; Start → it is written at BASE_ADDR.
6. DELAY_SLOT_NOP_EN: J Target=26'h0000010 → 32'h08000010 at addr 0, 32'h0 at addr 1, Count=2, InReady low between the two writes.
